// File: rtl/mmio_counter_bank.sv
// rtl/mmio_counter_bank.sv - bank of NUM_CH memory-mapped counters with compare, wrap, sticky flags and irq
module mmio_counter_bank #(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        dbus_en_i,
    input  logic [31:0]       dbus_write_addr_i,
    input  logic [31:0]       dbus_write_data_i,
    input  logic              dbus_read_en_i,
    input  logic [31:0]       dbus_read_addr_i,
    output logic [31:0]       dbus_read_data_o,
    input  logic [NUM_CH-1:0] evt_i,
    output logic              irq_o
);
    localparam int HI_W = CNT_W - 32;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0]       NCH4    = 4'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt    [NUM_CH];
    logic [CNT_W-1:0] r_cmp    [NUM_CH];
    logic [HI_W-1:0]  r_shadow [NUM_CH];
    logic [3:0]       r_ctrl   [NUM_CH];
    logic [1:0]       r_status [NUM_CH];
    logic             r_irq;

    logic [CNT_W-1:0] w_cnt_nxt    [NUM_CH];
    logic [CNT_W-1:0] w_cmp_nxt    [NUM_CH];
    logic [HI_W-1:0]  w_shadow_nxt [NUM_CH];
    logic [3:0]       w_ctrl_nxt   [NUM_CH];
    logic [1:0]       w_status_nxt [NUM_CH];
    logic [1:0]       w_set        [NUM_CH];
    logic [1:0]       w_clr        [NUM_CH];
    logic [NUM_CH-1:0] w_tick;
    logic [NUM_CH-1:0] w_wsel;
    logic             w_irq_nxt;

    logic        w_wr, w_wr_hit, w_rd_hit;
    logic [2:0]  w_wr_ch, w_rd_ch, w_wr_off, w_rd_off;
    logic [CH_W-1:0] w_rd_idx;
    logic [31:0] w_mask;
    logic        w_unused_addr_lsbs;

    assign w_wr     = |dbus_en_i;
    assign w_wr_ch  = dbus_write_addr_i[7:5];
    assign w_wr_off = dbus_write_addr_i[4:2];
    assign w_rd_ch  = dbus_read_addr_i[7:5];
    assign w_rd_off = dbus_read_addr_i[4:2];
    assign w_rd_idx = w_rd_ch[CH_W-1:0];
    assign w_wr_hit = w_wr && (dbus_write_addr_i[31:8] == BASE_ADDR[31:8]) && ({1'b0, w_wr_ch} < NCH4);
    assign w_rd_hit = (dbus_read_addr_i[31:8] == BASE_ADDR[31:8]) && ({1'b0, w_rd_ch} < NCH4);
    assign w_mask   = {{8{dbus_en_i[3]}}, {8{dbus_en_i[2]}}, {8{dbus_en_i[1]}}, {8{dbus_en_i[0]}}};
    assign w_unused_addr_lsbs = ^{dbus_write_addr_i[1:0], dbus_read_addr_i[1:0]};
    assign irq_o    = r_irq;

    function automatic logic [31:0] merge_lo(input logic [31:0] old_v, input logic [31:0] d,
                                             input logic [31:0] m);
        return (old_v & ~m) | (d & m);
    endfunction

    // HI words are zero-extended to 32 bits; lanes above CNT_W fall away on truncation
    function automatic logic [HI_W-1:0] merge_hi(input logic [HI_W-1:0] old_v, input logic [31:0] d,
                                                 input logic [31:0] m);
        logic [31:0] t;
        t = (32'(old_v) & ~m) | (d & m);
        return t[HI_W-1:0];
    endfunction

    always_comb begin
        w_irq_nxt = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_wsel[ch]       = w_wr_hit && (w_wr_ch == 3'(ch));
            w_tick[ch]       = r_ctrl[ch][0] & (r_ctrl[ch][1] ? evt_i[ch] : 1'b1);
            w_cnt_nxt[ch]    = r_cnt[ch];
            w_cmp_nxt[ch]    = r_cmp[ch];
            w_ctrl_nxt[ch]   = r_ctrl[ch];
            w_shadow_nxt[ch] = r_shadow[ch];
            w_set[ch]        = 2'b00;
            w_clr[ch]        = 2'b00;

            // software counter writes suppress that cycle's tick entirely
            if (w_wsel[ch] && w_wr_off == 3'd0) begin
                w_cnt_nxt[ch][31:0] = merge_lo(r_cnt[ch][31:0], dbus_write_data_i, w_mask);
            end else if (w_wsel[ch] && w_wr_off == 3'd1) begin
                w_cnt_nxt[ch][CNT_W-1:32] = merge_hi(r_cnt[ch][CNT_W-1:32], dbus_write_data_i, w_mask);
            end else if (w_tick[ch]) begin
                if (r_cnt[ch] == r_cmp[ch]) begin
                    w_set[ch][0] = 1'b1;
                    w_set[ch][1] = !r_ctrl[ch][2] && (r_cnt[ch] == CNT_MAX);
                    w_cnt_nxt[ch] = r_ctrl[ch][2] ? '0 : r_cnt[ch] + CNT_ONE;
                end else if (r_cnt[ch] == CNT_MAX) begin
                    w_set[ch][1]  = 1'b1;
                    w_cnt_nxt[ch] = '0;
                end else begin
                    w_cnt_nxt[ch] = r_cnt[ch] + CNT_ONE;
                end
            end

            if (w_wsel[ch] && w_wr_off == 3'd2 && dbus_en_i[0])
                w_ctrl_nxt[ch] = dbus_write_data_i[3:0];
            if (w_wsel[ch] && w_wr_off == 3'd3 && dbus_en_i[0])
                w_clr[ch] = dbus_write_data_i[1:0];
            if (w_wsel[ch] && w_wr_off == 3'd4)
                w_cmp_nxt[ch][31:0] = merge_lo(r_cmp[ch][31:0], dbus_write_data_i, w_mask);
            if (w_wsel[ch] && w_wr_off == 3'd5)
                w_cmp_nxt[ch][CNT_W-1:32] = merge_hi(r_cmp[ch][CNT_W-1:32], dbus_write_data_i, w_mask);
            if (dbus_read_en_i && w_rd_hit && w_rd_ch == 3'(ch) && w_rd_off == 3'd0)
                w_shadow_nxt[ch] = r_cnt[ch][CNT_W-1:32];

            w_status_nxt[ch] = (r_status[ch] & ~w_clr[ch]) | w_set[ch];
            w_irq_nxt = w_irq_nxt | ((|r_status[ch]) & r_ctrl[ch][3]);
        end
    end

    always_comb begin
        dbus_read_data_o = '0;
        if (w_rd_hit) begin
            case (w_rd_off)
                3'd0:    dbus_read_data_o = r_cnt[w_rd_idx][31:0];
                3'd1:    dbus_read_data_o = 32'(r_shadow[w_rd_idx]);
                3'd2:    dbus_read_data_o = {28'd0, r_ctrl[w_rd_idx]};
                3'd3:    dbus_read_data_o = {30'd0, r_status[w_rd_idx]};
                3'd4:    dbus_read_data_o = r_cmp[w_rd_idx][31:0];
                3'd5:    dbus_read_data_o = 32'(r_cmp[w_rd_idx][CNT_W-1:32]);
                default: dbus_read_data_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_cnt[ch]    <= '0;
                r_cmp[ch]    <= '1;
                r_shadow[ch] <= '0;
                r_ctrl[ch]   <= '0;
                r_status[ch] <= '0;
            end
        end else begin
            r_irq <= w_irq_nxt;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_cnt[ch]    <= w_cnt_nxt[ch];
                r_cmp[ch]    <= w_cmp_nxt[ch];
                r_shadow[ch] <= w_shadow_nxt[ch];
                r_ctrl[ch]   <= w_ctrl_nxt[ch];
                r_status[ch] <= w_status_nxt[ch];
            end
        end
    end
endmodule

// File: tb/tb_mmio_counter_bank.sv
// tb/tb_mmio_counter_bank.sv - directed bench for mmio_counter_bank (NUM_CH=4, CNT_W=40)
module tb_mmio_counter_bank;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  dbus_en_i;
    logic [31:0] dbus_write_addr_i;
    logic [31:0] dbus_write_data_i;
    logic        dbus_read_en_i;
    logic [31:0] dbus_read_addr_i;
    logic [31:0] dbus_read_data_o;
    logic [3:0]  evt_i;
    logic        irq_o;

    int n_vec = 0;
    int n_err = 0;

    mmio_counter_bank #(.NUM_CH(4), .CNT_W(40), .BASE_ADDR(BASE)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .dbus_en_i(dbus_en_i),
        .dbus_write_addr_i(dbus_write_addr_i), .dbus_write_data_i(dbus_write_data_i),
        .dbus_read_en_i(dbus_read_en_i), .dbus_read_addr_i(dbus_read_addr_i),
        .dbus_read_data_o(dbus_read_data_o), .evt_i(evt_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ra(input int ch, input int off);
        return BASE + 32'(ch * 32 + off);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        dbus_en_i = be; dbus_write_addr_i = a; dbus_write_data_i = d;
        tick();
        dbus_en_i = 4'b0000;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        dbus_read_addr_i = a;
        #1;
        chk(tag, dbus_read_data_o, exp);
    endtask

    task automatic rd_strobe(input string tag, input logic [31:0] a, input logic [31:0] exp);
        dbus_read_en_i = 1'b1;
        rd(tag, a, exp);
        tick();
        dbus_read_en_i = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] e);
        evt_i = e; tick(); evt_i = 4'b0000; tick();
    endtask

    initial begin
        rst_i = 1'b1; dbus_en_i = '0; dbus_write_addr_i = '0; dbus_write_data_i = '0;
        dbus_read_en_i = 1'b0; dbus_read_addr_i = '0; evt_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        for (int ch = 0; ch < 4; ch++) rd("rst_cnt_lo", ra(ch, 'h00), 32'd0);
        rd("rst_cnt_hi", ra(2, 'h04), 32'd0);
        rd("rst_cmp_lo", ra(0, 'h10), 32'hFFFF_FFFF);
        rd("rst_cmp_hi", ra(3, 'h14), 32'h0000_00FF);
        rd("rst_status", ra(1, 'h0C), 32'd0);

        // free-run: 10 idle ticks plus the tick on the disabling write edge
        wr(ra(0, 'h08), 32'd1, 4'hF);
        repeat (10) tick();
        wr(ra(0, 'h08), 32'd0, 4'hF);
        rd("free_cnt", ra(0, 'h00), 32'd11);
        repeat (5) tick();
        rd("free_hold", ra(0, 'h00), 32'd11);
        rd("free_ctrl", ra(0, 'h08), 32'd0);

        // atomic 40-bit read through the shadow
        wr(ra(1, 'h00), 32'hFFFF_FFFE, 4'hF);
        wr(ra(1, 'h04), 32'd0, 4'hF);
        wr(ra(1, 'h08), 32'd1, 4'hF);
        rd_strobe("atom_lo", ra(1, 'h00), 32'hFFFF_FFFE);
        tick();
        rd("atom_hi_shadow", ra(1, 'h04), 32'd0);
        rd_strobe("atom_lo2", ra(1, 'h00), 32'd0);
        rd("atom_hi_live", ra(1, 'h04), 32'd1);
        wr(ra(1, 'h08), 32'd0, 4'hF);

        // compare with wrap and interrupt on ch2
        wr(ra(2, 'h10), 32'd4, 4'hF);
        wr(ra(2, 'h14), 32'd0, 4'hF);
        wr(ra(2, 'h08), 32'hD, 4'hF);
        rd("cmp_seq0", ra(2, 'h00), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            rd("cmp_seq", ra(2, 'h00), 32'(i));
        end
        tick();
        rd("cmp_wrap", ra(2, 'h00), 32'd0);
        rd("cmp_match", ra(2, 'h0C), 32'd1);
        chk("irq_lag", {31'd0, irq_o}, 32'd0);
        tick();
        chk("irq_rise", {31'd0, irq_o}, 32'd1);
        rd("cmp_after", ra(2, 'h00), 32'd1);
        wr(ra(2, 'h0C), 32'd1, 4'hF);
        rd("w1c_status", ra(2, 'h0C), 32'd0);
        chk("irq_hold", {31'd0, irq_o}, 32'd1);
        tick();
        chk("irq_fall", {31'd0, irq_o}, 32'd0);
        wr(ra(2, 'h08), 32'd0, 4'hF);
        rd("cmp_stop", ra(2, 'h00), 32'd4);

        // event source on ch3
        wr(ra(3, 'h08), 32'd3, 4'hF);
        repeat (3) pulse(4'b1000);
        repeat (5) pulse(4'b0001);
        rd("evt_cnt", ra(3, 'h00), 32'd3);
        rd("evt_ch0_idle", ra(0, 'h00), 32'd11);
        evt_i = 4'b1000;
        wr(ra(3, 'h00), 32'd100, 4'hF);
        evt_i = 4'b0000;
        rd("evt_wr_wins", ra(3, 'h00), 32'd100);
        rd("evt_no_flag", ra(3, 'h0C), 32'd0);
        wr(ra(3, 'h08), 32'd0, 4'hF);

        // overflow at all ones with default CMP: both flags
        wr(ra(1, 'h04), 32'hFFFF_FFFF, 4'hF);
        wr(ra(1, 'h00), 32'hFFFF_FFFF, 4'hF);
        rd_strobe("ovf_pre_lo", ra(1, 'h00), 32'hFFFF_FFFF);
        rd("ovf_pre_hi", ra(1, 'h04), 32'h0000_00FF);
        wr(ra(1, 'h08), 32'd1, 4'hF);
        wr(ra(1, 'h08), 32'd0, 4'hF);
        rd_strobe("ovf_lo", ra(1, 'h00), 32'd0);
        rd("ovf_hi", ra(1, 'h04), 32'd0);
        rd("ovf_status", ra(1, 'h0C), 32'd3);
        rd("ovf_cmp_lo", ra(1, 'h10), 32'hFFFF_FFFF);
        rd("ovf_cmp_hi", ra(1, 'h14), 32'h0000_00FF);
        chk("ovf_no_irq", {31'd0, irq_o}, 32'd0);

        // overflow with CMP elsewhere: OVF only
        wr(ra(0, 'h10), 32'd5, 4'hF);
        wr(ra(0, 'h00), 32'hFFFF_FFFF, 4'hF);
        wr(ra(0, 'h04), 32'h0000_00FF, 4'hF);
        wr(ra(0, 'h08), 32'd1, 4'hF);
        wr(ra(0, 'h08), 32'd0, 4'hF);
        rd("ovf2_lo", ra(0, 'h00), 32'd0);
        rd("ovf2_status", ra(0, 'h0C), 32'd2);

        // decode and byte lanes
        wr(ra(4, 'h08), 32'hFFFF_FFFF, 4'hF);
        rd("dec_outside", ra(4, 'h08), 32'd0);
        rd("dec_ctrl0", ra(0, 'h08), 32'd0);
        rd("dec_unused_off", ra(0, 'h18), 32'd0);
        wr(ra(3, 'h10), 32'h1234_5678, 4'b0010);
        rd("byte_lane", ra(3, 'h10), 32'hFFFF_56FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
